logic_arbiter: RTL and testbench

Shares one combinational `logic_block` (16-bit AND/OR/XOR/NOT unit) among NREQ requesters. It arbitrates round-robin and registers the winner's operands. It returns the result with the winner's ID over a valid/ready response port. It sits between the instruction-issue ports and the shared logic datapath and is the only block that drives `logic_block` inputs.

---
 rtl/logic_arb_pkg.sv | 30 +++
 rtl/logic_arbiter_rr_pick.sv | 33 +++
 rtl/logic_block.sv | 23 ++
 rtl/logic_arbiter.sv | 141 ++++++++++++++
 tb/tb_logic_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_arb_pkg.sv
// Shared types and constants for the round-robin logic-unit arbiter.
package logic_arb_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned SEL_W  = 3;

   localparam logic [SEL_W-1:0] OP_AND = 3'b000;
   localparam logic [SEL_W-1:0] OP_OR  = 3'b001;
   localparam logic [SEL_W-1:0] OP_XOR = 3'b010;
   localparam logic [SEL_W-1:0] OP_NOT = 3'b100;

   // Response slot state: IDLE holds nothing, FULL holds one result.
   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } arb_state_t;

   // Operand bundle captured from the winning requester.
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [SEL_W-1:0]  sel;
   } op_t;

   // True for the four opcodes the logic unit implements.
   function automatic logic is_legal_op(input logic [SEL_W-1:0] sel);
      return (sel == OP_AND) || (sel == OP_OR) || (sel == OP_XOR) || (sel == OP_NOT);
   endfunction

endpackage

// File: rtl/logic_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   // Walk NREQ candidates starting at ptr; first hit wins.
   always_comb begin
      int unsigned cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!any && req[IDW'(cand)]) begin
            any                = 1'b1;
            grant[IDW'(cand)]  = 1'b1;
            idx                = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/logic_block.sv
// Shared 16-bit combinational logic unit (AND/OR/XOR/NOT); unused opcodes give 0.
module logic_block
   import logic_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] y
);

   // Opcode decode.
   always_comb begin
      y = '0;
      case (sel)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOT:  y = ~a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logic_block among NREQ requesters.
// Optional illegal-opcode flagging is built when LOGIC_ARB_OPCHK_EN is defined.
module logic_arbiter
   import logic_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*DATA_W-1:0]  req_a,
   input  logic [NREQ*DATA_W-1:0]  req_b,
   input  logic [NREQ*SEL_W-1:0]   req_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_err
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic [IDW-1:0]    ptr_q;
   logic [IDW-1:0]    ptr_d;
   logic [IDW-1:0]    id_q;
   op_t               op_q;
   op_t               win_op;
   logic [NREQ-1:0]   pick_grant;
   logic [IDW-1:0]    pick_idx;
   logic              pick_any;
   logic              slot_free;
   logic              accept;
   logic [DATA_W-1:0] lb_y;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // FSM state register; reset empties the response slot immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a grant always (re)fills the slot, a consume without grant empties it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (rsp_ready && !accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and handshake: grant only while the slot can take a new result.
   always_comb begin
      rsp_valid = (state_q == FULL);
      slot_free = (state_q == IDLE) || rsp_ready;
      req_ready = slot_free ? pick_grant : '0;
      accept    = slot_free && pick_any;
   end

   // Operand mux for the winning requester.
   always_comb begin
      win_op = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_grant[i]) begin
            win_op.a   = req_a[DATA_W*i +: DATA_W];
            win_op.b   = req_b[DATA_W*i +: DATA_W];
            win_op.sel = req_sel[SEL_W*i +: SEL_W];
         end
      end
   end

   // Pointer advances past the winner, wrapping at NREQ-1 for non-power-of-two NREQ.
   always_comb begin
      ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
   end

   // Capture winner operands, ID and next pointer on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= '0;
         id_q  <= '0;
         ptr_q <= '0;
      end else if (accept) begin
         op_q  <= win_op;
         id_q  <= pick_idx;
         ptr_q <= ptr_d;
      end
   end

   logic_block u_lb (
      .a   (op_q.a),
      .b   (op_q.b),
      .sel (op_q.sel),
      .y   (lb_y)
   );

   assign rsp_id = id_q;

`ifdef LOGIC_ARB_OPCHK_EN
   logic err_q;

   // Illegal-opcode flag travels with the captured operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= !is_legal_op(win_op.sel);
      end
   end

   assign rsp_err  = err_q;
   assign rsp_data = err_q ? '0 : lb_y;
`else
   assign rsp_err  = 1'b0;
   assign rsp_data = lb_y;
`endif

endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: vector table with a response scoreboard,
// plus hand-written sequences for NREQ=3 pointer wrap and mid-transaction reset.
module tb_logic_arbiter;

`ifdef LOGIC_ARB_OPCHK_EN
   localparam bit OPCHK = 1'b1;
`else
   localparam bit OPCHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [11:0] req_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_err;

   logic [2:0]  req_valid3;
   logic [2:0]  req_ready3;
   logic [47:0] req_a3;
   logic [47:0] req_b3;
   logic [8:0]  req_sel3;
   logic        rsp_valid3;
   logic        rsp_ready3;
   logic [15:0] rsp_data3;
   logic [1:0]  rsp_id3;
   logic        rsp_err3;

   logic_arbiter #(.NREQ(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err)
   );

   logic_arbiter #(.NREQ(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid3),
      .req_ready (req_ready3),
      .req_a     (req_a3),
      .req_b     (req_b3),
      .req_sel   (req_sel3),
      .rsp_valid (rsp_valid3),
      .rsp_ready (rsp_ready3),
      .rsp_data  (rsp_data3),
      .rsp_id    (rsp_id3),
      .rsp_err   (rsp_err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      logic [11:0] sel;
      logic        rdy;
      logic [3:0]  exp_ready;
      logic [15:0] exp_data;
      logic        ill;
   } row_t;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  id;
      logic        err;
   } exp_t;

   row_t rows[$];
   exp_t sb[$];
   int   n_pass;
   int   n_total;
   bit   model_valid;

   function automatic row_t mk(input logic [3:0] valid, input logic [15:0] a, input logic [15:0] b,
                               input logic [11:0] sel, input logic rdy, input logic [3:0] exp_ready,
                               input logic [15:0] exp_data, input logic ill);
      row_t r;
      r.valid     = valid;
      r.a         = a;
      r.b         = b;
      r.sel       = sel;
      r.rdy       = rdy;
      r.exp_ready = exp_ready;
      r.exp_data  = exp_data;
      r.ill       = ill;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_sel    = '0;
      rsp_ready  = 1'b0;
      req_valid3 = '0;
      req_a3     = '0;
      req_b3     = '0;
      req_sel3   = '0;
      rsp_ready3 = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n       = 1'b0;
      model_valid = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_data", 32'(rsp_data), 32'h0);
      chk("reset_rsp_id", 32'(rsp_id), 32'h0);
      chk("reset_rsp_err", 32'(rsp_err), 32'h0);
      chk("reset_req_ready", 32'(req_ready), 32'h0);
      chk("reset_rsp_valid3", 32'(rsp_valid3), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One row per cycle: drive, check held/consumed result, check grant, push new expectation.
   task automatic run_rows(input int lo, input int hi);
      for (int r = lo; r <= hi; r++) begin
         exp_t e;
         @(posedge clk);
         #1;
         req_valid = rows[r].valid;
         req_a     = {4{rows[r].a}};
         req_b     = {4{rows[r].b}};
         req_sel   = rows[r].sel;
         rsp_ready = rows[r].rdy;
         #1;
         chk($sformatf("row%0d_rsp_valid", r), 32'(rsp_valid), 32'(model_valid));
         if (model_valid) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL row%0d_scoreboard: got empty queue expected one pending result", r);
            end else begin
               chk($sformatf("row%0d_rsp_data", r), 32'(rsp_data), 32'(sb[0].data));
               chk($sformatf("row%0d_rsp_id", r), 32'(rsp_id), 32'(sb[0].id));
               chk($sformatf("row%0d_rsp_err", r), 32'(rsp_err), 32'(sb[0].err));
               if (rows[r].rdy) begin
                  void'(sb.pop_front());
               end
            end
         end
         chk($sformatf("row%0d_req_ready", r), 32'(req_ready), 32'(rows[r].exp_ready));
         if (rows[r].exp_ready != 4'b0000) begin
            e.data = rows[r].exp_data;
            e.err  = rows[r].ill & OPCHK;
            e.id   = 2'b00;
            for (int i = 0; i < 4; i++) begin
               if (rows[r].exp_ready[i]) e.id = 2'(i);
            end
            sb.push_back(e);
         end
         model_valid = (rows[r].exp_ready != 4'b0000) || (model_valid && !rows[r].rdy);
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      idle_inputs();

      // Single request after reset.
      rows.push_back(mk(4'b0001, 16'h00FF, 16'h0F0F, 12'h000, 1'b1, 4'b0001, 16'h000F, 1'b0));
      rows.push_back(mk(4'b0000, 16'h0000, 16'h0000, 12'h000, 1'b1, 4'b0000, 16'h0000, 1'b0));
      // All four valid, rsp_ready high: grants 0,1,2,3,0. Sel req0=OR req1=XOR req2=NOT req3=AND.
      rows.push_back(mk(4'b1111, 16'hAAAA, 16'h5555, 12'h111, 1'b1, 4'b0001, 16'hFFFF, 1'b0));
      rows.push_back(mk(4'b1111, 16'hAAAA, 16'h5555, 12'h111, 1'b1, 4'b0010, 16'hFFFF, 1'b0));
      rows.push_back(mk(4'b1111, 16'hAAAA, 16'h5555, 12'h111, 1'b1, 4'b0100, 16'h5555, 1'b0));
      rows.push_back(mk(4'b1111, 16'hAAAA, 16'h5555, 12'h111, 1'b1, 4'b1000, 16'h0000, 1'b0));
      rows.push_back(mk(4'b1111, 16'hAAAA, 16'h5555, 12'h111, 1'b1, 4'b0001, 16'hFFFF, 1'b0));
      rows.push_back(mk(4'b0000, 16'h0000, 16'h0000, 12'h000, 1'b1, 4'b0000, 16'h0000, 1'b0));
      // Backpressure: req0 fills slot, req1/req2 wait three cycles, then drain in order.
      rows.push_back(mk(4'b0001, 16'h1234, 16'h00FF, 12'h088, 1'b0, 4'b0001, 16'h0034, 1'b0));
      rows.push_back(mk(4'b0110, 16'h1234, 16'h00FF, 12'h088, 1'b0, 4'b0000, 16'h0000, 1'b0));
      rows.push_back(mk(4'b0110, 16'h1234, 16'h00FF, 12'h088, 1'b0, 4'b0000, 16'h0000, 1'b0));
      rows.push_back(mk(4'b0110, 16'h1234, 16'h00FF, 12'h088, 1'b0, 4'b0000, 16'h0000, 1'b0));
      rows.push_back(mk(4'b0110, 16'h1234, 16'h00FF, 12'h088, 1'b1, 4'b0010, 16'h12FF, 1'b0));
      rows.push_back(mk(4'b0100, 16'h1234, 16'h00FF, 12'h088, 1'b1, 4'b0100, 16'h12CB, 1'b0));
      rows.push_back(mk(4'b0000, 16'h0000, 16'h0000, 12'h000, 1'b1, 4'b0000, 16'h0000, 1'b0));
      // Illegal opcode 111 from req3.
      rows.push_back(mk(4'b1000, 16'hFFFF, 16'hFFFF, 12'hE00, 1'b1, 4'b1000, 16'h0000, 1'b1));
      rows.push_back(mk(4'b0000, 16'h0000, 16'h0000, 12'h000, 1'b1, 4'b0000, 16'h0000, 1'b0));

      do_reset();
      run_rows(0, 1);
      do_reset();
      run_rows(2, rows.size() - 1);

      // NREQ=3 pointer wrap: grant req2, pointer wraps to 0, then req0 beats req2.
      do_reset();
      @(posedge clk);
      #1;
      req_valid3 = 3'b100;
      req_a3     = {3{16'h00FF}};
      req_b3     = {3{16'h0F0F}};
      req_sel3   = '0;
      rsp_ready3 = 1'b1;
      #1;
      chk("wrap3_first_grant", 32'(req_ready3), 32'h4);
      @(posedge clk);
      #1;
      chk("wrap3_rsp_id2", 32'(rsp_id3), 32'h2);
      chk("wrap3_rsp_data", 32'(rsp_data3), 32'h000F);
      req_valid3 = 3'b101;
      #1;
      chk("wrap3_req0_first", 32'(req_ready3), 32'h1);
      @(posedge clk);
      #1;
      chk("wrap3_rsp_id0", 32'(rsp_id3), 32'h0);
      req_valid3 = 3'b100;
      #1;
      chk("wrap3_then_req2", 32'(req_ready3), 32'h4);
      @(posedge clk);
      #1;
      req_valid3 = '0;
      chk("wrap3_rsp_id2b", 32'(rsp_id3), 32'h2);

      // Reset while a result is held under backpressure.
      do_reset();
      @(posedge clk);
      #1;
      req_valid = 4'b0010;
      req_a     = {4{16'h00FF}};
      req_b     = {4{16'h0F0F}};
      req_sel   = '0;
      rsp_ready = 1'b0;
      #1;
      chk("mid_grant_req1", 32'(req_ready), 32'h2);
      @(posedge clk);
      #1;
      req_valid = '0;
      chk("mid_rsp_valid_before", 32'(rsp_valid), 32'h1);
      chk("mid_rsp_id_before", 32'(rsp_id), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rsp_valid_async", 32'(rsp_valid), 32'h0);
      chk("mid_rsp_data_cleared", 32'(rsp_data), 32'h0);
      chk("mid_rsp_id_cleared", 32'(rsp_id), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      chk("post_reset_grant_req2", 32'(req_ready), 32'h4);
      @(posedge clk);
      #1;
      chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("post_reset_rsp_id", 32'(rsp_id), 32'h2);
      chk("post_reset_rsp_data", 32'(rsp_data), 32'h000F);
      req_valid = 4'b1101;
      #1;
      chk("post_reset_ptr3", 32'(req_ready), 32'h8);
      @(posedge clk);
      #1;
      idle_inputs();
      chk("post_reset_rsp_id3", 32'(rsp_id), 32'h3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
